my_ep_tx_cpl_engine: RTL and testbench
======================================

Name: my_ep_tx_cpl_engine

Overview:
- Downstream neighbour of the endpoint memory controller: consumes its completion request (req_compl / req_compl_with_data plus the latched request fields) and returns the completion-done pulse.
- Reads one DW from the controller's register/memory read port.
- Formats a 3DW-header PCIe Cpl or CplD TLP and drives it onto the 32-bit Spartan-6 TRN transmit interface, honouring destination back-pressure.

Parameters:
- RD_LATENCY, 1, cycles from rd_addr_o/rd_be_o valid to rd_data_i valid; legal values 1 or 2.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_compl_i  in  1  one-cycle pulse: completion requested
- req_compl_with_data_i  in  1  qualifies req_compl_i: 1 = CplD, 0 = Cpl
- req_tc_i  in  3  traffic class
- req_td_i  in  1  TLP digest bit
- req_ep_i  in  1  poisoned bit
- req_attr_i  in  2  attributes
- req_len_i  in  10  request length in DW; only 1 supported
- req_rid_i  in  16  requester ID
- req_tag_i  in  8  request tag
- req_be_i  in  8  {last BE, first BE}; only [3:0] used
- req_addr_i  in  13  byte address
- completer_id_i  in  16  {bus, device, function}
- compl_done_o  out  1  one-cycle pulse after EOF beat accepted
- rd_addr_o  out  11  DW read address = req_addr[12:2]
- rd_be_o  out  4  read byte enables = req_be[3:0]
- rd_data_i  in  32  read data
- trn_td  out  32  TLP data
- trn_tsof_n  out  1  start of frame, active low
- trn_teof_n  out  1  end of frame, active low
- trn_tsrc_rdy_n  out  1  source ready, active low
- trn_tsrc_dsc_n  out  1  source discontinue; tied 1
- trn_tdst_rdy_n  in  1  destination ready, active low
- trn_tbuf_av  in  6  TX buffer availability

Behaviour:
- Reset values (asynchronous, immediate): trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n and trn_tsrc_dsc_n = 1; trn_td = 0; compl_done_o = 0; rd_addr_o = 0; rd_be_o = 0; state = IDLE.
- Reset mid-packet aborts the packet with no compl_done_o. The upstream block is reset by the same rst_n.

States:
- IDLE: on req_compl_i, latch all req_* fields and the with_data flag; drive rd_addr_o/rd_be_o from the latched values; go to FETCH.
- FETCH: wait RD_LATENCY cycles, then register rd_data_i into the data latch and go to WAIT_BUF.
- WAIT_BUF: stay until trn_tbuf_av != 0, then go to HDR0.
- HDR0, HDR1, HDR2, DATA: one beat each, with trn_tsrc_rdy_n = 0 throughout.
  - A beat advances only in a cycle where trn_tdst_rdy_n = 0. Otherwise trn_td and the flags hold stable.
  - trn_tsof_n = 0 on HDR0 only.
  - trn_teof_n = 0 on HDR2 for Cpl and on DATA for CplD. Cpl skips DATA.
- DONE: pulse compl_done_o for exactly 1 cycle, deassert trn_tsrc_rdy_n, return to IDLE.
- New request timing: earliest new req_compl_i is accepted the cycle after DONE.
- req_compl_i outside IDLE is ignored; upstream guarantees it waits for compl_done_o.

TLP fields:
- DW0 = {0, fmt[1:0], 5'b01010, 0, tc, 4'b0, td, ep, attr, 2'b0, length}
  - fmt = 2'b10 for CplD, 2'b00 for Cpl.
  - length = req_len for CplD, 0 for Cpl.
- DW1 = {completer_id_i, status 3'b000, BCM 0, byte_count[11:0]}
- DW2 = {rid, tag, 0, lower_addr[6:0]}
- DW3 = latched read data.

byte_count from first BE:
- 4 for 1xx1
- 3 for 01x1 or 1x10
- 2 for 0011, 0110 or 1100
- 1 for any single bit set or 0000

lower_addr:
- {addr[6:2], 2-bit offset of the lowest set BE bit}
- offset 00 when BE = 0000

Optional Feature:
MY_EP_TX_BSWAP_EN
- Defined: DW3 is byte-swapped ({d[7:0], d[15:8], d[23:16], d[31:24]}) to match PCIe byte order.
- Undefined: rd_data passes unmodified.
- Headers are never swapped in either case.

Test Plan:
1. CplD: tc/td/ep/attr = 0, len 1, rid 0, tag 5, be 8'h0F, addr 13'h10, completer_id 16'h0100, rd_data 32'hDEADBEEF, dst_rdy always 0 -> rd_addr_o = 4; beats 0x4A000001, 0x01000004, 0x00000510, 0xDEADBEEF; SOF on beat 1, EOF on beat 4; compl_done_o one pulse. With MY_EP_TX_BSWAP_EN, DW3 = 0xEFBEADDE.
2. Cpl (with_data = 0), same fields -> 3 beats 0x0A000000, 0x01000004, 0x00000510; EOF on beat 3; no DATA beat.
3. be 8'h06, addr 13'h14 -> DW1 byte_count 2; DW2 lower_addr 0x15.
4. trn_tdst_rdy_n held 1 for 3 cycles during HDR1 -> trn_td stays 0x01000004 and flags stable; packet resumes intact; compl_done_o delayed by 3 cycles.
5. trn_tbuf_av = 0 for 10 cycles after request -> trn_tsrc_rdy_n stays 1 until trn_tbuf_av != 0; second req_compl_i pulsed while busy is ignored (exactly one TLP, one compl_done_o).
6. rst_n asserted during DATA beat -> outputs immediately return to reset values; no compl_done_o; a new request after reset completes normally.

Source files
------------

// File: rtl/my_ep_tx_cpl_engine.sv
// my_ep_tx_cpl_engine: completion TX engine for the PIO endpoint.
// Takes a completion request from the memory controller, reads one DW from its
// read port, then sends a 3DW-header Cpl/CplD TLP over the 32-bit TRN TX interface.
// Ports: req_* request fields and req_compl_i strobe in; compl_done_o pulse out;
//   rd_addr_o/rd_be_o/rd_data_i read port; trn_* transmit interface.
// Optional build macro: MY_EP_TX_BSWAP_EN byte-swaps the data DW (never the headers).
module my_ep_tx_cpl_engine #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_compl_i,
  input  logic        req_compl_with_data_i,
  input  logic [2:0]  req_tc_i,
  input  logic        req_td_i,
  input  logic        req_ep_i,
  input  logic [1:0]  req_attr_i,
  input  logic [9:0]  req_len_i,
  input  logic [15:0] req_rid_i,
  input  logic [7:0]  req_tag_i,
  input  logic [7:0]  req_be_i,
  input  logic [12:0] req_addr_i,
  input  logic [15:0] completer_id_i,
  output logic        compl_done_o,
  output logic [10:0] rd_addr_o,
  output logic [3:0]  rd_be_o,
  input  logic [31:0] rd_data_i,
  output logic [31:0] trn_td,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  output logic        trn_tsrc_dsc_n,
  input  logic        trn_tdst_rdy_n,
  input  logic [5:0]  trn_tbuf_av
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_BUF,
    HDR0,
    HDR1,
    HDR2,
    DATA,
    DONE
  } state_t;

  localparam logic [1:0] LAT = RD_LATENCY[1:0];

  state_t      state;
  state_t      next_state;

  logic        with_data;
  logic [2:0]  tc;
  logic        td;
  logic        ep;
  logic [1:0]  attr;
  logic [9:0]  len;
  logic [15:0] rid;
  logic [7:0]  tag;
  logic [31:0] data;
  logic [1:0]  lat_cnt;

  logic [31:0] dw0;
  logic [31:0] dw1;
  logic [31:0] dw2;
  logic [31:0] dw3;
  logic [11:0] byte_count;
  logic [6:0]  lower_addr;

  logic        unused_bits;
  assign unused_bits = ^{req_be_i[7:4], req_addr_i[1:0]};

  function automatic logic [11:0] calc_byte_count(input logic [3:0] be);
    logic [11:0] bc;
    casez (be)
      4'b1??1:                   bc = 12'd4;
      4'b01?1, 4'b1?10:          bc = 12'd3;
      4'b0011, 4'b0110, 4'b1100: bc = 12'd2;
      default:                   bc = 12'd1;
    endcase
    return bc;
  endfunction

  function automatic logic [1:0] calc_offset(input logic [3:0] be);
    logic [1:0] off;
    if (be[0])      off = 2'd0;
    else if (be[1]) off = 2'd1;
    else if (be[2]) off = 2'd2;
    else if (be[3]) off = 2'd3;
    else            off = 2'd0;
    return off;
  endfunction

  // rd_addr_o holds req_addr[12:2], so its low 5 bits are req_addr[6:2]
  assign byte_count = calc_byte_count(rd_be_o);
  assign lower_addr = {rd_addr_o[4:0], calc_offset(rd_be_o)};

  assign dw0 = {1'b0, with_data, 1'b0, 5'b01010, 1'b0, tc, 4'b0000,
                td, ep, attr, 2'b00, (with_data ? len : 10'd0)};
  assign dw1 = {completer_id_i, 3'b000, 1'b0, byte_count};
  assign dw2 = {rid, tag, 1'b0, lower_addr};

`ifdef MY_EP_TX_BSWAP_EN
  assign dw3 = {data[7:0], data[15:8], data[23:16], data[31:24]};
`else
  assign dw3 = data;
`endif

  assign trn_tsrc_dsc_n = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      with_data <= 1'b0;
      tc        <= '0;
      td        <= 1'b0;
      ep        <= 1'b0;
      attr      <= '0;
      len       <= '0;
      rid       <= '0;
      tag       <= '0;
      rd_addr_o <= '0;
      rd_be_o   <= '0;
      data      <= '0;
      lat_cnt   <= '0;
    end else begin
      if (state == IDLE && req_compl_i) begin
        with_data <= req_compl_with_data_i;
        tc        <= req_tc_i;
        td        <= req_td_i;
        ep        <= req_ep_i;
        attr      <= req_attr_i;
        len       <= req_len_i;
        rid       <= req_rid_i;
        tag       <= req_tag_i;
        rd_addr_o <= req_addr_i[12:2];
        rd_be_o   <= req_be_i[3:0];
      end
      if (state == FETCH) begin
        lat_cnt <= lat_cnt + 2'd1;
      end else begin
        lat_cnt <= '0;
      end
      if (state == FETCH && lat_cnt == LAT) begin
        data <= rd_data_i;
      end
    end
  end

  // TRN outputs decode straight from state so a reset clears them immediately
  always_comb begin
    next_state     = state;
    trn_td         = '0;
    trn_tsof_n     = 1'b1;
    trn_teof_n     = 1'b1;
    trn_tsrc_rdy_n = 1'b1;
    compl_done_o   = 1'b0;
    case (state)
      IDLE: begin
        if (req_compl_i) next_state = FETCH;
      end
      FETCH: begin
        if (lat_cnt == LAT) next_state = WAIT_BUF;
      end
      WAIT_BUF: begin
        if (trn_tbuf_av != 6'd0) next_state = HDR0;
      end
      HDR0: begin
        trn_td         = dw0;
        trn_tsof_n     = 1'b0;
        trn_tsrc_rdy_n = 1'b0;
        if (!trn_tdst_rdy_n) next_state = HDR1;
      end
      HDR1: begin
        trn_td         = dw1;
        trn_tsrc_rdy_n = 1'b0;
        if (!trn_tdst_rdy_n) next_state = HDR2;
      end
      HDR2: begin
        trn_td         = dw2;
        trn_teof_n     = with_data;
        trn_tsrc_rdy_n = 1'b0;
        if (!trn_tdst_rdy_n) next_state = with_data ? DATA : DONE;
      end
      DATA: begin
        trn_td         = dw3;
        trn_teof_n     = 1'b0;
        trn_tsrc_rdy_n = 1'b0;
        if (!trn_tdst_rdy_n) next_state = DONE;
      end
      DONE: begin
        compl_done_o = 1'b1;
        next_state   = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_my_ep_tx_cpl_engine.sv
module tb_my_ep_tx_cpl_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_compl_i = 1'b0;
  logic        req_compl_with_data_i = 1'b0;
  logic [2:0]  req_tc_i = '0;
  logic        req_td_i = 1'b0;
  logic        req_ep_i = 1'b0;
  logic [1:0]  req_attr_i = '0;
  logic [9:0]  req_len_i = '0;
  logic [15:0] req_rid_i = '0;
  logic [7:0]  req_tag_i = '0;
  logic [7:0]  req_be_i = '0;
  logic [12:0] req_addr_i = '0;
  logic [15:0] completer_id_i = '0;
  logic        compl_done_o;
  logic [10:0] rd_addr_o;
  logic [3:0]  rd_be_o;
  logic [31:0] rd_data_i = '0;
  logic [31:0] trn_td;
  logic        trn_tsof_n;
  logic        trn_teof_n;
  logic        trn_tsrc_rdy_n;
  logic        trn_tsrc_dsc_n;
  logic        trn_tdst_rdy_n = 1'b0;
  logic [5:0]  trn_tbuf_av = 6'd8;

  int passed = 0;
  int total = 0;

  logic [10:0] cur_addr = '0;
  logic [31:0] cur_data = '0;

  my_ep_tx_cpl_engine #(.RD_LATENCY(1)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .req_compl_i           (req_compl_i),
    .req_compl_with_data_i (req_compl_with_data_i),
    .req_tc_i              (req_tc_i),
    .req_td_i              (req_td_i),
    .req_ep_i              (req_ep_i),
    .req_attr_i            (req_attr_i),
    .req_len_i             (req_len_i),
    .req_rid_i             (req_rid_i),
    .req_tag_i             (req_tag_i),
    .req_be_i              (req_be_i),
    .req_addr_i            (req_addr_i),
    .completer_id_i        (completer_id_i),
    .compl_done_o          (compl_done_o),
    .rd_addr_o             (rd_addr_o),
    .rd_be_o               (rd_be_o),
    .rd_data_i             (rd_data_i),
    .trn_td                (trn_td),
    .trn_tsof_n            (trn_tsof_n),
    .trn_teof_n            (trn_teof_n),
    .trn_tsrc_rdy_n        (trn_tsrc_rdy_n),
    .trn_tsrc_dsc_n        (trn_tsrc_dsc_n),
    .trn_tdst_rdy_n        (trn_tdst_rdy_n),
    .trn_tbuf_av           (trn_tbuf_av)
  );

  always #5 clk = ~clk;

  // one-cycle read memory; returns junk unless the expected address is presented
  always @(posedge clk) rd_data_i <= (rd_addr_o == cur_addr) ? cur_data : 32'hBAD0BAD0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wd;
    logic [2:0]  tc;
    logic        td;
    logic        ep;
    logic [1:0]  attr;
    logic [9:0]  len;
    logic [15:0] rid;
    logic [15:0] cid;
    logic [7:0]  tag;
    logic [7:0]  be;
    logic [12:0] addr;
    logic [31:0] data;
    logic [10:0] rdaddr;
    logic [31:0] dw0;
    logic [31:0] dw1;
    logic [31:0] dw2;
    logic [31:0] dw3;
    int          nbeats;
    int          done_k;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [31:0] exp_data(input logic [31:0] d);
`ifdef MY_EP_TX_BSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  function automatic vec_t mk(input logic wd, input logic [2:0] tc, input logic td,
                              input logic ep, input logic [1:0] attr, input logic [15:0] rid,
                              input logic [15:0] cid, input logic [7:0] tag, input logic [7:0] be,
                              input logic [12:0] addr, input logic [31:0] data,
                              input logic [10:0] rdaddr, input logic [31:0] dw0,
                              input logic [31:0] dw1, input logic [31:0] dw2);
    vec_t v;
    v.wd = wd; v.tc = tc; v.td = td; v.ep = ep; v.attr = attr; v.len = 10'd1;
    v.rid = rid; v.cid = cid; v.tag = tag; v.be = be; v.addr = addr; v.data = data;
    v.rdaddr = rdaddr; v.dw0 = dw0; v.dw1 = dw1; v.dw2 = dw2; v.dw3 = exp_data(data);
    v.nbeats = wd ? 4 : 3;
    v.done_k = wd ? 8 : 7;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic run_tlp(input string name, input vec_t v, input int stall_beat,
                         input int stall_len, input int buf_hold, input int extra_req_at,
                         input int exp_done_k);
    logic [31:0] bd[8];
    logic        bs[8];
    logic        bf[8];
    logic [34:0] snap;
    int          nb, ndone, done_k, stalled, hold_bad, buf_viol;
    nb = 0; ndone = 0; done_k = -1; stalled = 0; hold_bad = 0; buf_viol = 0; snap = '0;
    for (int i = 0; i < 8; i++) begin bd[i] = '0; bs[i] = 1'b1; bf[i] = 1'b1; end
    @(negedge clk);
    cur_addr = v.rdaddr; cur_data = v.data;
    req_compl_with_data_i = v.wd; req_tc_i = v.tc; req_td_i = v.td; req_ep_i = v.ep;
    req_attr_i = v.attr; req_len_i = v.len; req_rid_i = v.rid; completer_id_i = v.cid;
    req_tag_i = v.tag; req_be_i = v.be; req_addr_i = v.addr;
    req_compl_i = 1'b1;
    trn_tdst_rdy_n = 1'b0;
    trn_tbuf_av = (buf_hold > 0) ? 6'd0 : 6'd8;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      req_compl_i = (k == extra_req_at);
      if (k == extra_req_at) begin
        req_tag_i = 8'hEE; req_compl_with_data_i = 1'b0; req_addr_i = 13'h1FFC;
      end
      if (k == 1) begin
        check({name, "_rd_addr"}, {21'd0, rd_addr_o}, {21'd0, v.rdaddr});
        check({name, "_rd_be"}, {28'd0, rd_be_o}, {28'd0, v.be[3:0]});
      end
      if (trn_tbuf_av == 6'd0 && !trn_tsrc_rdy_n) buf_viol++;
      if (k == buf_hold) trn_tbuf_av = 6'd8;
      if (compl_done_o) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end
      if (!trn_tsrc_rdy_n) begin
        if (nb == stall_beat && stalled < stall_len) begin
          if (stalled == 0) snap = {trn_td, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n};
          else if (snap != {trn_td, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n}) hold_bad++;
          stalled++;
          trn_tdst_rdy_n = 1'b1;
        end else begin
          if (stalled > 0 && nb == stall_beat &&
              snap != {trn_td, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n}) hold_bad++;
          if (nb < 8) begin bd[nb] = trn_td; bs[nb] = trn_tsof_n; bf[nb] = trn_teof_n; end
          nb++;
          trn_tdst_rdy_n = 1'b0;
        end
      end else begin
        trn_tdst_rdy_n = 1'b0;
      end
    end
    check({name, "_nbeats"}, nb, v.nbeats);
    for (int i = 0; i < v.nbeats; i++) begin
      check($sformatf("%s_beat%0d", name, i), bd[i],
            (i == 0) ? v.dw0 : (i == 1) ? v.dw1 : (i == 2) ? v.dw2 : v.dw3);
      check($sformatf("%s_sof%0d", name, i), {31'd0, bs[i]}, (i == 0) ? 32'd0 : 32'd1);
      check($sformatf("%s_eof%0d", name, i), {31'd0, bf[i]}, (i == v.nbeats - 1) ? 32'd0 : 32'd1);
    end
    check({name, "_done_count"}, ndone, 1);
    if (exp_done_k > 0) check({name, "_done_cycle"}, done_k, exp_done_k);
    if (stall_len > 0) check({name, "_hold_stable"}, hold_bad, 0);
    if (buf_hold > 0) check({name, "_no_rdy_without_buf"}, buf_viol, 0);
    trn_tbuf_av = 6'd8;
    trn_tdst_rdy_n = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_sof"}, {31'd0, trn_tsof_n}, 32'd1);
    check({name, "_eof"}, {31'd0, trn_teof_n}, 32'd1);
    check({name, "_src_rdy"}, {31'd0, trn_tsrc_rdy_n}, 32'd1);
    check({name, "_dsc"}, {31'd0, trn_tsrc_dsc_n}, 32'd1);
    check({name, "_td"}, trn_td, 32'd0);
    check({name, "_done"}, {31'd0, compl_done_o}, 32'd0);
    check({name, "_rd_addr"}, {21'd0, rd_addr_o}, 32'd0);
    check({name, "_rd_be"}, {28'd0, rd_be_o}, 32'd0);
  endtask

  initial begin
    logic found;
    int   late_done;
    //            wd  tc    td ep attr   rid       cid       tag    be     addr      data          rdaddr   dw0           dw1           dw2
    vecs[0] = mk(1, 3'd0, 0, 0, 2'd0, 16'h0000, 16'h0100, 8'h05, 8'h0F, 13'h0010, 32'hDEADBEEF, 11'h004, 32'h4A000001, 32'h01000004, 32'h00000510);
    vecs[1] = mk(0, 3'd0, 0, 0, 2'd0, 16'h0000, 16'h0100, 8'h05, 8'h0F, 13'h0010, 32'hDEADBEEF, 11'h004, 32'h0A000000, 32'h01000004, 32'h00000510);
    vecs[2] = mk(1, 3'd0, 0, 0, 2'd0, 16'h0000, 16'h0100, 8'h05, 8'h06, 13'h0014, 32'h12345678, 11'h005, 32'h4A000001, 32'h01000002, 32'h00000515);
    vecs[3] = mk(1, 3'd0, 0, 0, 2'd0, 16'h0000, 16'h0100, 8'hA5, 8'h08, 13'h001C, 32'hCAFEF00D, 11'h007, 32'h4A000001, 32'h01000001, 32'h0000A51F);
    vecs[4] = mk(0, 3'd0, 0, 0, 2'd0, 16'h0000, 16'h0100, 8'hFF, 8'h00, 13'h07FC, 32'h55AA55AA, 11'h1FF, 32'h0A000000, 32'h01000001, 32'h0000FF7C);
    vecs[5] = mk(1, 3'd0, 0, 0, 2'd0, 16'h0000, 16'h0100, 8'h12, 8'h0D, 13'h0020, 32'h00000001, 11'h008, 32'h4A000001, 32'h01000004, 32'h00001220);
    vecs[6] = mk(1, 3'd0, 0, 0, 2'd0, 16'h0000, 16'h0100, 8'h33, 8'h05, 13'h0044, 32'hA5A55A5A, 11'h011, 32'h4A000001, 32'h01000003, 32'h00003344);
    vecs[7] = mk(1, 3'd0, 0, 0, 2'd0, 16'h0000, 16'h0100, 8'h01, 8'h0A, 13'h0008, 32'h11223344, 11'h002, 32'h4A000001, 32'h01000003, 32'h00000109);
    vecs[8] = mk(1, 3'd7, 1, 1, 2'd3, 16'hBEEF, 16'h1234, 8'h00, 8'h0C, 13'h0100, 32'h0F1E2D3C, 11'h040, 32'h4A70F001, 32'h12340002, 32'hBEEF0002);

    #1;
    check_reset_outputs("por");
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int unsigned i = 0; i < 9; i++) begin
      run_tlp($sformatf("vec%0d", i), vecs[i], -1, 0, 0, -1, vecs[i].done_k);
    end

    // destination back-pressure on HDR1 for three cycles
    run_tlp("stall_hdr1", vecs[0], 1, 3, 0, -1, 11);

    // no TX buffer for ten cycles, plus a request pulse while busy
    run_tlp("buf_wait", vecs[0], -1, 0, 10, 5, 15);

    // reset while the DATA beat is presented
    @(negedge clk);
    cur_addr = vecs[0].rdaddr; cur_data = vecs[0].data;
    req_compl_with_data_i = 1'b1; req_tag_i = 8'h05; req_be_i = 8'h0F; req_addr_i = 13'h0010;
    req_rid_i = '0; completer_id_i = 16'h0100; req_tc_i = '0; req_td_i = 1'b0;
    req_ep_i = 1'b0; req_attr_i = '0; req_len_i = 10'd1;
    req_compl_i = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      req_compl_i = 1'b0;
      if (!trn_tsrc_rdy_n && !trn_teof_n) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_reached_data", {31'd0, found}, 32'd1);
    trn_tdst_rdy_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    trn_tdst_rdy_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    late_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (compl_done_o || !trn_tsrc_rdy_n) late_done++;
    end
    check("rst_no_done_after_abort", late_done, 0);
    run_tlp("after_rst", vecs[0], -1, 0, 0, -1, 8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
